// File: rtl/privacy_sram_pkg.sv
// privacy_sram_pkg: shared FSM state type and default parameters
// for the privacy SRAM controller and its wordline decoder.
package privacy_sram_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ACC, S_DONE} state_t;
    localparam int DEF_DATA_W  = 10;
    localparam int DEF_ROWS    = 64;
    localparam int DEF_PRE_CYC = 1;
    localparam int DEF_ACC_CYC = 2;
endpackage

// File: rtl/privacy_sram_wl_dec.sv
// privacy_sram_wl_dec: row address to one-hot wordline decode;
// addresses at or beyond ROWS match no row and give an all-zero wl.
module privacy_sram_wl_dec
    import privacy_sram_pkg::*;
#(
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [ROWS-1:0]   o_wl
);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign o_wl[r] = i_en && (i_addr == ADDR_W'(r));
    end
endmodule

// File: rtl/privacy_sram_ctrl.sv
// privacy_sram_ctrl: precharge/access sequencer for an SRAM macro with one-cycle response pulse.
// Define PRIVACY_ZEROIZE_EN to enable the zero_req full-array wipe sweep.
module privacy_sram_ctrl
    import privacy_sram_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROWS    = DEF_ROWS,
    parameter int PRE_CYC = DEF_PRE_CYC,
    parameter int ACC_CYC = DEF_ACC_CYC
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [$clog2(ROWS)-1:0]  req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    input  logic                     zero_req,
    output logic                     zero_busy,
    output logic                     pre_b,
    output logic [ROWS-1:0]          wl,
    output logic                     rd_en,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        arr_din,
    input  logic [DATA_W-1:0]        arr_dout
);
    localparam int ADDR_W  = $clog2(ROWS);
    localparam int CNT_MAX = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we, r_zero;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [ROWS-1:0]     w_wl;
    logic                w_zstart, w_accept, w_pre_last, w_acc_last, w_zero_more, w_in_range, w_acc;

`ifdef PRIVACY_ZEROIZE_EN
    assign w_zstart = (r_state == S_IDLE) && zero_req;
`else
    logic w_unused;
    assign w_unused = zero_req;
    assign w_zstart = 1'b0;
`endif

    assign req_ready   = wb_rst_n && (r_state == S_IDLE) && !w_zstart;
    assign w_accept    = req_ready && req_valid;
    assign w_pre_last  = r_cnt == CNT_W'(PRE_CYC - 1);
    assign w_acc_last  = r_cnt == CNT_W'(ACC_CYC - 1);
    assign w_zero_more = r_zero && (r_addr != ADDR_W'(ROWS - 1));
    assign w_acc       = r_state == S_ACC;
    assign w_in_range  = |w_wl;

    privacy_sram_wl_dec #(.ROWS(ROWS), .ADDR_W(ADDR_W)) u_wl_dec (
        .i_addr (r_addr),
        .i_en   (w_acc),
        .o_wl   (w_wl)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = (w_zstart || w_accept) ? S_PRE : S_IDLE;
            S_PRE:   w_next = w_pre_last ? S_ACC : S_PRE;
            S_ACC:   w_next = w_acc_last ? (w_zero_more ? S_PRE : S_DONE) : S_ACC;
            default: w_next = S_IDLE;
        endcase
    end

    assign wl        = w_wl;
    assign pre_b     = r_state != S_PRE;
    assign rd_en     = w_acc && !r_we;
    assign wr_en     = w_acc && r_we;
    assign arr_din   = (w_acc && r_we) ? r_wdata : '0;
    assign rsp_valid = r_state == S_DONE;
    assign rsp_rdata = (r_state == S_DONE) ? r_rdata : '0;
    assign zero_busy = r_zero;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_zero  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == r_state) ? r_cnt + 1'b1 : '0;
            if (w_zstart) begin
                r_zero  <= 1'b1;
                r_we    <= 1'b1;
                r_addr  <= '0;
                r_wdata <= '0;
            end else if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            // Out-of-range reads see no wordline, so they return zero.
            if (w_acc && w_acc_last) begin
                r_rdata <= (!r_we && w_in_range) ? arr_dout : '0;
                if (w_zero_more)
                    r_addr <= r_addr + 1'b1;
            end
            if (r_state == S_DONE)
                r_zero <= 1'b0;
        end
    end
endmodule

// File: tb/tb_privacy_sram_ctrl.sv
// tb_privacy_sram_ctrl: directed checks of privacy_sram_ctrl against a behavioural SRAM macro,
// plus a ROWS=48 instance sharing the request inputs for out-of-range decode.
module tb_privacy_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, zero_req;
    logic [5:0]  req_addr;
    logic [9:0]  req_wdata;
    logic        req_ready, rsp_valid, zero_busy, pre_b, rd_en, wr_en;
    logic [9:0]  rsp_rdata, arr_din, arr_dout;
    logic [63:0] wl;
    logic        req_ready48, rsp_valid48, zero_busy48, pre_b48, rd_en48, wr_en48;
    logic [9:0]  rsp_rdata48, arr_din48;
    logic [47:0] wl48;
    logic [9:0]  mem [64];
    int          wl_idx;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    privacy_sram_ctrl u_dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .zero_req(zero_req), .zero_busy(zero_busy), .pre_b(pre_b),
        .wl(wl), .rd_en(rd_en), .wr_en(wr_en), .arr_din(arr_din), .arr_dout(arr_dout)
    );

    privacy_sram_ctrl #(.ROWS(48)) u_dut48 (
        .wb_clk_i(clk), .wb_rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready48),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid48),
        .rsp_rdata(rsp_rdata48), .zero_req(zero_req), .zero_busy(zero_busy48), .pre_b(pre_b48),
        .wl(wl48), .rd_en(rd_en48), .wr_en(wr_en48), .arr_din(arr_din48), .arr_dout(10'h155)
    );

    always_comb begin
        wl_idx = 0;
        for (int i = 0; i < 64; i++)
            if (wl[i]) wl_idx = i;
    end

    assign arr_dout = rd_en ? mem[wl_idx] : '0;

    always @(posedge clk)
        if (wr_en && |wl) mem[wl_idx] <= arr_din;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("inv_wl_onehot", 64'($onehot0(wl)), 64'd1);
        chk("inv_rd_wr", 64'(rd_en & wr_en), 64'd0);
        chk("inv_pre_wl", 64'(!pre_b && |wl), 64'd0);
        chk("inv48_wl_onehot", 64'($onehot0(wl48)), 64'd1);
        chk("inv48_pre_wl", 64'(!pre_b48 && |wl48), 64'd0);
    end

    // Issues one access from an IDLE negedge and returns at the negedge after the response.
    task automatic access(input logic we, input logic [5:0] addr, input logic [9:0] wd,
                          output logic [9:0] rd, output logic [9:0] rd48, output int lat,
                          output logic [63:0] wl_or, output int wl_cyc, output logic [47:0] wl48_or);
        int  t;
        bit  got;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; got = 0; rd = '0; rd48 = '0; wl_or = '0; wl_cyc = 0; wl48_or = '0;
        while (!got && lat < 20) begin
            wl_or |= wl; wl48_or |= wl48;
            if (|wl) wl_cyc++;
            if (rsp_valid) begin
                got = 1; rd = rsp_rdata; rd48 = rsp_rdata48;
            end else begin
                @(negedge clk); lat++;
            end
        end
        if (!got) lat = 99;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0]  rd, rd48;
        logic [63:0] wl_or, prev_wl;
        logic [47:0] wl48_or;
        int          lat, wl_cyc, t, na, nr, wr_cyc, rows, next_row, pulses;
        int          acc_t [2];
        logic [9:0]  rsp_d [2];
        bit          asc_ok;
        for (int i = 0; i < 64; i++) mem[i] = 10'(10'h100 + i);
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; zero_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_pre_b", 64'(pre_b), 64'd1);
        chk("rst_wl", wl, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_zero_busy", 64'(zero_busy), 64'd0);
        rst_n = 1'b1;
        #1 chk("rel_ready", 64'(req_ready), 64'd1);

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 10'h2A5;
        chk("wr_ready", 64'(req_ready), 64'd1);
        @(negedge clk); req_valid = 1'b0;
        chk("wr_pre_pre_b", 64'(pre_b), 64'd0);
        chk("wr_pre_wl", wl, 64'd0);
        chk("wr_pre_wr_en", 64'(wr_en), 64'd0);
        @(negedge clk);
        chk("wr_acc_wl", wl, 64'd1 << 5);
        chk("wr_acc_wr_en", 64'(wr_en), 64'd1);
        chk("wr_acc_rd_en", 64'(rd_en), 64'd0);
        chk("wr_acc_din", 64'(arr_din), 64'h2A5);
        @(negedge clk);
        chk("wr_acc2_wr_en", 64'(wr_en), 64'd1);
        @(negedge clk);
        chk("wr_done_valid", 64'(rsp_valid), 64'd1);
        chk("wr_done_rdata", 64'(rsp_rdata), 64'd0);
        @(negedge clk);
        chk("wr_idle_valid", 64'(rsp_valid), 64'd0);
        chk("wr_idle_ready", 64'(req_ready), 64'd1);

        access(1'b0, 6'd5, 10'h0, rd, rd48, lat, wl_or, wl_cyc, wl48_or);
        chk("rd5_latency", 64'(lat), 64'd4);
        chk("rd5_data", 64'(rd), 64'h2A5);
        chk("rd5_wl", wl_or, 64'd1 << 5);
        chk("rd5_wl_cycles", 64'(wl_cyc), 64'd2);

        access(1'b1, 6'd63, 10'h3FF, rd, rd48, lat, wl_or, wl_cyc, wl48_or);
        access(1'b1, 6'd0, 10'h001, rd, rd48, lat, wl_or, wl_cyc, wl48_or);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd63;
        t = 0; na = 0; nr = 0; acc_t = '{0, 0}; rsp_d = '{0, 0};
        while (nr < 2 && t < 40) begin
            if (req_ready && req_valid) begin acc_t[na] = t; na++; end
            if (rsp_valid) begin rsp_d[nr] = rsp_rdata; nr++; end
            @(negedge clk); t++;
            if (na == 1) req_addr = 6'd0;
            if (na == 2) req_valid = 1'b0;
        end
        chk("b2b_accepts", 64'(na), 64'd2);
        chk("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'd5);
        chk("b2b_rd63", 64'(rsp_d[0]), 64'h3FF);
        chk("b2b_rd0", 64'(rsp_d[1]), 64'h001);

        access(1'b0, 6'd50, 10'h0, rd, rd48, lat, wl_or, wl_cyc, wl48_or);
        chk("oor48_wl", 64'(wl48_or), 64'd0);
        chk("oor48_rdata", 64'(rd48), 64'd0);
        chk("rd50_data64", 64'(rd), 64'(10'h100 + 50));
        chk("rd50_wl64", wl_or, 64'd1 << 50);

        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7; req_wdata = 10'h123;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        chk("abort_acc_wr_en", 64'(wr_en), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wl", wl, 64'd0);
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_pre_b", 64'(pre_b), 64'd1);
        chk("abort_rsp", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        #1 chk("abort_ready", 64'(req_ready), 64'd1);
        pulses = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) pulses++; end
        chk("abort_no_rsp", 64'(pulses), 64'd0);

`ifdef PRIVACY_ZEROIZE_EN
        zero_req = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5;
        #1 chk("zero_blocks_ready", 64'(req_ready), 64'd0);
        @(negedge clk); zero_req = 1'b0; req_valid = 1'b0;
        chk("zero_busy_set", 64'(zero_busy), 64'd1);
        t = 1; wr_cyc = 0; rows = 0; next_row = 0; asc_ok = 1; prev_wl = '0; pulses = 0;
        while (!rsp_valid && t < 400) begin
            if (wr_en) wr_cyc++;
            if (|wl && prev_wl == 0) begin
                if (wl_idx != next_row) asc_ok = 0;
                next_row++; rows++;
            end
            if (!zero_busy) asc_ok = 0;
            prev_wl = wl;
            @(negedge clk); t++;
        end
        chk("zero_done_cycle", 64'(t), 64'd193);
        chk("zero_rdata", 64'(rsp_rdata), 64'd0);
        chk("zero_wr_cycles", 64'(wr_cyc), 64'd128);
        chk("zero_rows", 64'(rows), 64'd64);
        chk("zero_ascending_busy", 64'(asc_ok), 64'd1);
        @(negedge clk);
        chk("zero_busy_clear", 64'(zero_busy), 64'd0);
        repeat (4) begin if (rsp_valid) pulses++; @(negedge clk); end
        chk("zero_single_pulse", 64'(pulses), 64'd0);
        access(1'b0, 6'd5, 10'h0, rd, rd48, lat, wl_or, wl_cyc, wl48_or);
        chk("zero_rd5", 64'(rd), 64'd0);
        access(1'b0, 6'd63, 10'h0, rd, rd48, lat, wl_or, wl_cyc, wl48_or);
        chk("zero_rd63", 64'(rd), 64'd0);
`else
        zero_req = 1'b1;
        #1 chk("nozero_ready", 64'(req_ready), 64'd1);
        access(1'b0, 6'd5, 10'h0, rd, rd48, lat, wl_or, wl_cyc, wl48_or);
        chk("nozero_busy", 64'(zero_busy), 64'd0);
        chk("nozero_rd5", 64'(rd), 64'h2A5);
        chk("nozero_latency", 64'(lat), 64'd4);
        zero_req = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
